// File: rtl/clz_arbiter.sv
// clz_arbiter: two-requester round-robin front end for one shared
// leading-zero / leading-one counter with a single registered result slot.
module clz_arbiter #(
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic [31:0]      req0_data,
    input  logic             req0_clo,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [31:0]      req1_data,
    input  logic             req1_clo,
    output logic             req1_ready,
    output logic             rsp_valid,
    output logic             rsp_id,
    output logic [CNT_W-1:0] rsp_count,
    input  logic             rsp_ready
);

    typedef struct packed {
        logic             id;
        logic [CNT_W-1:0] count;
    } rsp_t;

    logic             rsp_valid_q, rsp_valid_d;
    rsp_t             rsp_q, rsp_d;
    logic             last_grant_q, last_grant_d;
    logic             can_accept;
    logic             grant_vld;
    logic             grant_id;
    logic             accept;
    logic [31:0]      operand;
    logic [CNT_W-1:0] lz_count;

    // Round-robin grant: a lone requester wins; on contention the one not served last wins
    always_comb begin
        grant_vld = req0_valid || req1_valid;
        grant_id  = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_id = ~last_grant_q;
        end else if (req1_valid) begin
            grant_id = 1'b1;
        end
    end

    // The slot can take a new operand when empty or being drained this cycle.
    // Readys are forced low while reset is asserted so nothing is handshaken then.
    assign can_accept = !rsp_valid_q || rsp_ready;
    assign req0_ready = rst_n && can_accept && grant_vld && !grant_id;
    assign req1_ready = rst_n && can_accept && grant_vld &&  grant_id;
    assign accept     = req0_ready || req1_ready;

    // Shared counter: CLO reuses the CLZ logic on the inverted operand
    always_comb begin
        operand  = grant_id ? (req1_data ^ {32{req1_clo}})
                            : (req0_data ^ {32{req0_clo}});
        lz_count = CNT_W'(32);
        // Scan upward so the highest set bit is the last to assign
        for (int i = 0; i < 32; i++) begin
            if (operand[i]) begin
                lz_count = CNT_W'(31 - i);
            end
        end
    end

    // Result slot next state: load on accept (also covers drain+accept), clear on drain, else hold
    always_comb begin
        rsp_valid_d  = rsp_valid_q;
        rsp_d        = rsp_q;
        last_grant_d = last_grant_q;
        if (accept) begin
            rsp_valid_d   = 1'b1;
            rsp_d.id      = grant_id;
            rsp_d.count   = lz_count;
            last_grant_d  = grant_id;
        end else if (rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    // State registers; last_grant resets to 1 so requester 0 wins the first contention
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_valid_q  <= 1'b0;
            rsp_q        <= '0;
            last_grant_q <= 1'b1;
        end else begin
            rsp_valid_q  <= rsp_valid_d;
            rsp_q        <= rsp_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_q.id;
    assign rsp_count = rsp_q.count;

endmodule

// File: tb/tb_clz_arbiter.sv
// tb_clz_arbiter: directed scenarios plus a random soak against a
// behavioural model of the arbiter and result slot.
module tb_clz_arbiter;

    localparam int CNT_W = 6;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             req0_valid = 1'b0;
    logic [31:0]      req0_data = '0;
    logic             req0_clo = 1'b0;
    logic             req0_ready;
    logic             req1_valid = 1'b0;
    logic [31:0]      req1_data = '0;
    logic             req1_clo = 1'b0;
    logic             req1_ready;
    logic             rsp_valid;
    logic             rsp_id;
    logic [CNT_W-1:0] rsp_count;
    logic             rsp_ready = 1'b0;

    int n_checks = 0;
    int n_fails  = 0;

    // Behavioural model state
    bit m_vld  = 1'b0;
    bit m_id   = 1'b0;
    bit m_last = 1'b1;
    int m_cnt  = 0;

    clz_arbiter #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_clo(req0_clo), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_clo(req1_clo), .req1_ready(req1_ready),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_count(rsp_count), .rsp_ready(rsp_ready)
    );

    always #5 clk = ~clk;

    // Leading-count reference: number of leading zeros (ones when clo) from the MSB
    function automatic int ref_count(input logic [31:0] d, input logic clo);
        logic [31:0] x;
        x = clo ? ~d : d;
        for (int k = 0; k < 32; k++) begin
            if (x[31-k]) return k;
        end
        return 32;
    endfunction

    // Grant reference: -1 means no grant
    function automatic int ref_grant(input logic v0, input logic v1, input bit last);
        if (v0 && v1) return last ? 0 : 1;
        if (v0) return 0;
        if (v1) return 1;
        return -1;
    endfunction

    // Advance one clock edge and move the model along with it; ends 1 time unit after the edge
    task automatic tick();
        int g;
        bit acc;
        g   = ref_grant(req0_valid, req1_valid, m_last);
        acc = rst_n && (!m_vld || rsp_ready) && (g >= 0);
        @(posedge clk);
        if (!rst_n) begin
            m_vld = 0; m_id = 0; m_cnt = 0; m_last = 1;
        end else if (acc) begin
            m_vld  = 1;
            m_id   = g[0];
            m_cnt  = (g == 1) ? ref_count(req1_data, req1_clo) : ref_count(req0_data, req0_clo);
            m_last = g[0];
        end else if (rsp_ready) begin
            m_vld = 0;
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 0; req0_valid = 1; req1_valid = 1; rsp_ready = 1;
        tick();
        tick();
        n_checks++;
        if ({rsp_valid, rsp_id, rsp_count} !== 8'h00) begin
            n_fails++;
            $display("FAIL reset_rsp got %b/%b/%0d exp 0/0/0", rsp_valid, rsp_id, rsp_count);
        end
        n_checks++;
        if ({req0_ready, req1_ready} !== 2'b00) begin
            n_fails++;
            $display("FAIL reset_ready got %b%b exp 00", req0_ready, req1_ready);
        end
        req0_valid = 0; req1_valid = 0;
        rst_n = 1;
    endtask

    // First cycle after release must already accept
    task automatic test_single();
        req0_valid = 1; req0_data = 32'h0001_0000; req0_clo = 0; rsp_ready = 1;
        #1;
        n_checks++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            n_fails++;
            $display("FAIL single_ready got %b%b exp 10", req0_ready, req1_ready);
        end
        tick();
        req0_valid = 0;
        n_checks++;
        if ({rsp_valid, rsp_id, rsp_count} !== {1'b1, 1'b0, 6'd15}) begin
            n_fails++;
            $display("FAIL single_rsp got %b/%b/%0d exp 1/0/15", rsp_valid, rsp_id, rsp_count);
        end
    endtask

    task automatic test_clo_extremes();
        bit          ids  [3] = '{1'b1, 1'b1, 1'b0};
        logic [31:0] dats [3] = '{32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        bit          clos [3] = '{1'b1, 1'b0, 1'b0};
        int          exps [3] = '{32, 32, 0};
        rsp_ready = 1;
        for (int i = 0; i < 3; i++) begin
            if (ids[i]) begin
                req1_valid = 1; req1_data = dats[i]; req1_clo = clos[i];
            end else begin
                req0_valid = 1; req0_data = dats[i]; req0_clo = clos[i];
            end
            #1;
            n_checks++;
            if ({req0_ready, req1_ready} !== {!ids[i], ids[i]}) begin
                n_fails++;
                $display("FAIL extreme%0d_ready got %b%b exp %b%b", i, req0_ready, req1_ready, !ids[i], ids[i]);
            end
            tick();
            req0_valid = 0; req1_valid = 0;
            n_checks++;
            if ({rsp_valid, rsp_id, rsp_count} !== {1'b1, ids[i], CNT_W'(exps[i])}) begin
                n_fails++;
                $display("FAIL extreme%0d_rsp got %b/%b/%0d exp 1/%b/%0d", i, rsp_valid, rsp_id, rsp_count, ids[i], exps[i]);
            end
        end
    endtask

    // After reset both requesters contend every cycle; grants alternate starting at 0
    task automatic test_contention();
        bit gi;
        rst_n = 0;
        tick();
        rst_n = 1;
        req0_valid = 1; req0_data = 32'h0000_0100; req0_clo = 0;   // count 23
        req1_valid = 1; req1_data = 32'h0F00_0000; req1_clo = 0;   // count 4
        rsp_ready = 1;
        for (int i = 0; i < 4; i++) begin
            gi = i[0];
            #1;
            n_checks++;
            if ({req0_ready, req1_ready} !== {!gi, gi}) begin
                n_fails++;
                $display("FAIL contend%0d_ready got %b%b exp %b%b", i, req0_ready, req1_ready, !gi, gi);
            end
            tick();
            n_checks++;
            if ({rsp_valid, rsp_id, rsp_count} !== {1'b1, gi, gi ? 6'd4 : 6'd23}) begin
                n_fails++;
                $display("FAIL contend%0d_rsp got %b/%b/%0d exp 1/%b/%0d", i, rsp_valid, rsp_id, rsp_count, gi, gi ? 4 : 23);
            end
        end
    endtask

    // Stall with both requesters waiting, then drain and accept in the same cycle
    task automatic test_backpressure();
        rsp_ready = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++;
            if ({req0_ready, req1_ready} !== 2'b00) begin
                n_fails++;
                $display("FAIL stall%0d_ready got %b%b exp 00", i, req0_ready, req1_ready);
            end
            n_checks++;
            if ({rsp_valid, rsp_id, rsp_count} !== {1'b1, 1'b1, 6'd4}) begin
                n_fails++;
                $display("FAIL stall%0d_rsp got %b/%b/%0d exp 1/1/4", i, rsp_valid, rsp_id, rsp_count);
            end
            tick();
        end
        rsp_ready = 1;
        #1;
        n_checks++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            n_fails++;
            $display("FAIL drain_accept_ready got %b%b exp 10", req0_ready, req1_ready);
        end
        tick();
        n_checks++;
        if ({rsp_valid, rsp_id, rsp_count} !== {1'b1, 1'b0, 6'd23}) begin
            n_fails++;
            $display("FAIL drain_accept_rsp got %b/%b/%0d exp 1/0/23", rsp_valid, rsp_id, rsp_count);
        end
        req0_valid = 0; req1_valid = 0;
        tick();
        n_checks++;
        if (rsp_valid !== 1'b0) begin
            n_fails++;
            $display("FAIL drain_only got rsp_valid=%b exp 0", rsp_valid);
        end
    endtask

    // Idle cycles keep the slot empty and leave the round-robin pointer alone
    task automatic test_idle();
        for (int i = 0; i < 3; i++) begin
            rsp_ready = 1'($urandom_range(1, 0));
            #1;
            n_checks++;
            if ({rsp_valid, req0_ready, req1_ready} !== 3'b000) begin
                n_fails++;
                $display("FAIL idle%0d got %b%b%b exp 000", i, rsp_valid, req0_ready, req1_ready);
            end
            tick();
        end
        rsp_ready = 1;
        req0_valid = 1; req0_data = 32'h0000_0001; req0_clo = 0;
        req1_valid = 1; req1_data = 32'h8000_0000; req1_clo = 1;   // CLO count 1
        #1;
        n_checks++;
        if ({req0_ready, req1_ready} !== 2'b01) begin
            n_fails++;
            $display("FAIL idle_rr_ready got %b%b exp 01", req0_ready, req1_ready);
        end
        tick();
        n_checks++;
        if ({rsp_valid, rsp_id, rsp_count} !== {1'b1, 1'b1, 6'd1}) begin
            n_fails++;
            $display("FAIL idle_rr_rsp got %b/%b/%0d exp 1/1/1", rsp_valid, rsp_id, rsp_count);
        end
        req0_valid = 0; req1_valid = 0;
        tick();
    endtask

    // Reset with a pending result, then requester 0 must win the first contention
    task automatic test_reset_mid();
        req0_valid = 1; req0_data = 32'h0; req0_clo = 0; rsp_ready = 0;
        tick();
        req0_valid = 0;
        n_checks++;
        if ({rsp_valid, rsp_id, rsp_count} !== {1'b1, 1'b0, 6'd32}) begin
            n_fails++;
            $display("FAIL rmid_pending got %b/%b/%0d exp 1/0/32", rsp_valid, rsp_id, rsp_count);
        end
        rst_n = 0; rsp_ready = 1;
        req0_valid = 1; req0_data = 32'h0001_0000; req0_clo = 0;
        req1_valid = 1; req1_data = 32'h0000_00FF; req1_clo = 0;
        #1;
        n_checks++;
        if ({req0_ready, req1_ready} !== 2'b00) begin
            n_fails++;
            $display("FAIL rmid_ready_in_reset got %b%b exp 00", req0_ready, req1_ready);
        end
        tick();
        n_checks++;
        if ({rsp_valid, rsp_id, rsp_count} !== 8'h00) begin
            n_fails++;
            $display("FAIL rmid_rsp got %b/%b/%0d exp 0/0/0", rsp_valid, rsp_id, rsp_count);
        end
        rst_n = 1;
        #1;
        n_checks++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            n_fails++;
            $display("FAIL rmid_first_grant got %b%b exp 10", req0_ready, req1_ready);
        end
        tick();
        n_checks++;
        if ({rsp_valid, rsp_id, rsp_count} !== {1'b1, 1'b0, 6'd15}) begin
            n_fails++;
            $display("FAIL rmid_after got %b/%b/%0d exp 1/0/15", rsp_valid, rsp_id, rsp_count);
        end
        req0_valid = 0; req1_valid = 0;
        tick();
    endtask

    // Random soak: per-cycle model compare, in-order scoreboard, starvation bound
    task automatic test_soak();
        bit          v   [2] = '{1'b0, 1'b0};
        logic [31:0] d   [2];
        bit          c   [2];
        int          opp [2] = '{0, 0};
        int          sb  [$];
        int          g;
        bit          can, acc, e0, e1;
        logic [6:0]  front;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            for (int n = 0; n < 2; n++) begin
                if (!v[n] && ($urandom_range(1, 0) == 1)) begin
                    v[n] = 1;
                    c[n] = 1'($urandom_range(1, 0));
                    case ($urandom_range(7, 0))
                        0:       d[n] = 32'h0000_0000;
                        1:       d[n] = 32'hFFFF_FFFF;
                        default: d[n] = $urandom >> $urandom_range(31, 0);
                    endcase
                end
            end
            req0_valid = v[0]; req0_data = d[0]; req0_clo = c[0];
            req1_valid = v[1]; req1_data = d[1]; req1_clo = c[1];
            rsp_ready  = ($urandom_range(3, 0) != 0);
            #1;
            g   = ref_grant(v[0], v[1], m_last);
            can = !m_vld || rsp_ready;
            acc = can && (g >= 0);
            e0  = acc && (g == 0);
            e1  = acc && (g == 1);
            n_checks++;
            if ({req0_ready, req1_ready} !== {e0, e1}) begin
                n_fails++;
                $display("FAIL soak_ready cyc %0d got %b%b exp %b%b", cyc, req0_ready, req1_ready, e0, e1);
            end
            n_checks++;
            if (rsp_valid !== m_vld || (m_vld && {rsp_id, rsp_count} !== {m_id, CNT_W'(m_cnt)})) begin
                n_fails++;
                $display("FAIL soak_rsp cyc %0d got %b/%b/%0d exp %b/%b/%0d",
                         cyc, rsp_valid, rsp_id, rsp_count, m_vld, m_id, m_cnt);
            end
            for (int n = 0; n < 2; n++) begin
                if (v[n] && can) begin
                    opp[n]++;
                    if (opp[n] >= 2) begin
                        n_checks++;
                        if (!(acc && g == n)) begin
                            n_fails++;
                            $display("FAIL soak_starve cyc %0d req%0d waited %0d opportunities exp <= 2", cyc, n, opp[n]);
                        end
                    end
                end
                if (acc && g == n) opp[n] = 0;
            end
            if (m_vld && rsp_ready) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_fails++;
                    $display("FAIL soak_sb cyc %0d got response %b/%0d exp none outstanding", cyc, rsp_id, rsp_count);
                end else begin
                    front = 7'(sb.pop_front());
                    if ({rsp_id, rsp_count} !== front) begin
                        n_fails++;
                        $display("FAIL soak_sb cyc %0d got %b/%0d exp %b/%0d", cyc, rsp_id, rsp_count, front[6], front[5:0]);
                    end
                end
            end
            if (acc) sb.push_back(g * 64 + ref_count(d[g], c[g]));
            tick();
            if (acc) v[g] = 0;
        end
        req0_valid = 0; req1_valid = 0;
        n_checks++;
        if (sb.size() != int'(m_vld)) begin
            n_fails++;
            $display("FAIL soak_sb_end got %0d outstanding exp %0d", sb.size(), int'(m_vld));
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_clo_extremes();
        test_contention();
        test_backpressure();
        test_idle();
        test_reset_mid();
        test_soak();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/clz_arbiter.md
CLZ_ARBITER -- requirements
Module: clz_arbiter

Interface
REQ-001 Parameter: CNT_W, default 6, width of the result count (must hold 0..32).
REQ-002 clk  input  1  rising-edge clock; the only clock.
REQ-003 rst_n  input  1  reset, synchronous and active-low.
REQ-004 req0_valid  input  1  requester 0 (CPU CLZ/CLO) has an operand.
REQ-005 req0_data  input  32  requester 0 operand.
REQ-006 req0_clo  input  1  1: count leading ones; 0: count leading zeros.
REQ-007 req0_ready  output  1  request 0 accepted this cycle when valid and ready are both high.
REQ-008 req1_valid, req1_data[31:0], req1_clo, req1_ready: same as REQ-004..007, for requester 1 (normalizer).
REQ-009 rsp_valid  output  1  result register holds a result.
REQ-010 rsp_id  output  1  requester that owns the result.
REQ-011 rsp_count  output  CNT_W  count result, 0..32.
REQ-012 rsp_ready  input  1  consumer takes the result when rsp_valid and rsp_ready are both high.

Function
REQ-013 One shared leading-zero counter; CLO is computed as CLZ of the bitwise-inverted operand.
REQ-014 Accept condition (can_accept) = !rsp_valid || rsp_ready.
REQ-015 At most one grant per cycle; reqN_ready = can_accept && grant==N; the ungranted ready is 0.
REQ-016 Grant, combinational from the valids:
- only one requester valid: that requester.
- both valid: the requester not recorded in last_grant.
- neither valid: no grant.
REQ-017 last_grant updates only on an accepted handshake, to the id that was accepted.
REQ-018 Latency: an operand accepted at edge N appears at edge N with rsp_valid=1, rsp_id=N, rsp_count=result. The result is registered. There is no combinational path from req*_data to rsp_*.
REQ-019 Result range: operand 0 (CLZ) or 0xFFFFFFFF (CLO) gives 32; MSB set (CLZ) or MSB clear (CLO) gives 0.
REQ-020 Simultaneous drain and accept (rsp_valid && rsp_ready && new handshake): the result register is overwritten with the new result; rsp_valid stays 1; no bubble.
REQ-021 Drain with no accept: rsp_valid goes to 0 at the next edge.
REQ-022 While rsp_valid=1 and rsp_ready=0:
- rsp_id and rsp_count are held stable.
- both readys are 0.
- requester inputs are ignored.
REQ-023 Occupancy: one result register; no request queueing. A requester must hold valid and data until it sees ready.
REQ-024 Starvation bound: a requester that holds valid is accepted within two accept opportunities.
REQ-025 Idle state: both valids low and rsp_valid=0; outputs stay stable and last_grant is unchanged.

Reset
REQ-026 When rst_n=0 at a rising edge, the block resets:
- rsp_valid=0, rsp_id=0, rsp_count=0.
- last_grant=1, so requester 0 wins the first contention.
REQ-027 During reset cycles, req0_ready and req1_ready are 0.
REQ-028 Reset mid-operation discards any pending result without a handshake. No input is sampled in the reset cycle.
REQ-029 In the first cycle after release, can_accept=1.

Verification
REQ-030 Single request: req0 valid, data 0x00010000, clo=0, rsp_ready=1 -> req0_ready=1; next cycle rsp_valid=1, id=0, count=15.
REQ-031 CLO and extremes: req1 with 0xFFFFFFFF, clo=1 -> count 32. req1 with 0x00000000, clo=0 -> 32. req0 with 0x80000000, clo=0 -> 0.
REQ-032 Contention after reset: both valid every cycle, rsp_ready=1 -> grants alternate 0,1,0,1. rsp_id follows one cycle later. A result is delivered every cycle.
REQ-033 Backpressure: result pending with rsp_ready=0 for 3 cycles -> both readys 0; rsp_count/rsp_id unchanged. When rsp_ready=1 with a request valid -> drain and accept in the same cycle (REQ-020).
REQ-034 Reset mid-operation: rsp_valid=1 and rst_n=0 for 1 cycle -> rsp_valid=0, rsp_count=0. Then both valid -> requester 0 granted first.
REQ-035 Random soak: 10k cycles of random valids, data, clo and rsp_ready. A scoreboard checks:
- every accepted operand yields exactly one response, in order, with the correct id and count.
- the REQ-024 starvation bound holds.
